// File: rtl/sipo_pkg.sv
// sipo_pkg: shared types and size helpers for the serial_in_parallel_out
// deserializer.
//   sipo_state_t    FSM state encoding (IDLE, SHIFT, FULL)
//   sipo_frame_len  serial bits per frame (adds one parity bit when
//                   SIPO_PARITY_CHECK_EN is defined)
//   sipo_cnt_width  bit counter width for a given frame length
package sipo_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    FULL  = 2'd2
  } sipo_state_t;

  function automatic int sipo_frame_len(input int width);
`ifdef SIPO_PARITY_CHECK_EN
    return width + 1;
`else
    return width;
`endif
  endfunction

  function automatic int sipo_cnt_width(input int frame_len);
    return $clog2(frame_len + 1);
  endfunction

endpackage

// File: rtl/sipo_out_slot.sv
// sipo_out_slot: one-word output register with valid/ready handshake.
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   load, load_data  write a new word into the slot (sets q_valid)
//   q_data, q_valid  held word and its valid flag
//   q_ready          downstream consumes the word when q_valid && q_ready
//   free             slot can accept a word on this edge
module sipo_out_slot #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  output logic [WIDTH-1:0] q_data,
  output logic             q_valid,
  input  logic             q_ready,
  output logic             free
);

  // A consume and a load on the same edge keep q_valid high with new data.
  assign free = !q_valid || q_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_data  <= '0;
      q_valid <= 1'b0;
    end else if (load) begin
      q_data  <= load_data;
      q_valid <= 1'b1;
    end else if (q_valid && q_ready) begin
      q_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/serial_in_parallel_out.sv
// serial_in_parallel_out: serial-to-parallel deserializer with a one-word
// output slot and input-side backpressure.
// Optional feature macro: SIPO_PARITY_CHECK_EN (adds a trailing even-parity
// bit per frame; bad frames are dropped and flagged on par_err).
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   sin, sin_valid     serial bit and its qualifier
//   sin_ready          bit accepted when sin_valid && sin_ready
//   frame_sync         accepted bit starts a new frame (partial one dropped)
//   q_data, q_valid    assembled word, valid until consumed
//   q_ready            downstream consume strobe
//   par_err            one-cycle pulse on parity mismatch (0 without parity)
//
// state | meaning
// IDLE  | no partial frame, count 0, accepting bits
// SHIFT | frame in progress, accepting bits
// FULL  | complete word parked in shift register, waiting for output slot
module serial_in_parallel_out
  import sipo_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sin,
  input  logic             sin_valid,
  output logic             sin_ready,
  input  logic             frame_sync,
  output logic [WIDTH-1:0] q_data,
  output logic             q_valid,
  input  logic             q_ready,
  output logic             par_err
);

  localparam int FRAME_LEN = sipo_frame_len(WIDTH);
  localparam int CW        = sipo_cnt_width(FRAME_LEN);
  localparam logic [CW-1:0] LAST_CNT = CW'(FRAME_LEN - 1);

  sipo_state_t      state;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] sreg;
  logic [WIDTH-1:0] shift_next;
  logic [WIDTH-1:0] word_next;
  logic [WIDTH-1:0] load_data;
  logic             accept;
  logic             restart;
  logic             last_bit;
  logic             par_ok;
  logic             shift_en;
  logic             load;
  logic             free;

  // Decoded from registered state only; q_ready never reaches sin_ready.
  assign sin_ready = !rst && (state != FULL);
  assign accept    = sin_valid && sin_ready;
  assign restart   = accept && (frame_sync || state == IDLE);
  // FRAME_LEN >= 2, so a restarting bit can never also be the last bit.
  assign last_bit  = accept && !restart && (count == LAST_CNT);

  // Stale bits from a dropped partial frame are pushed out by the time a
  // full frame has shifted in, so a restart needs no clear.
  generate
    if (MSB_FIRST != 0) begin : g_msb_first
      assign shift_next = {sreg[WIDTH-2:0], sin};
    end else begin : g_lsb_first
      assign shift_next = {sin, sreg[WIDTH-1:1]};
    end
  endgenerate

`ifdef SIPO_PARITY_CHECK_EN
  logic par_acc;
  logic par_err_q;

  // Parity bit sits at count == WIDTH and is not shifted into the data.
  assign shift_en  = restart || (count < CW'(WIDTH));
  assign word_next = sreg;
  assign par_ok    = (par_acc ^ sin) == 1'b0;
  assign par_err   = par_err_q;
`else
  assign shift_en  = 1'b1;
  assign word_next = shift_next;
  assign par_ok    = 1'b1;
  assign par_err   = 1'b0;
`endif

  assign load      = free && ((last_bit && par_ok) || state == FULL);
  assign load_data = (state == FULL) ? sreg : word_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      count <= '0;
      sreg  <= '0;
`ifdef SIPO_PARITY_CHECK_EN
      par_acc   <= 1'b0;
      par_err_q <= 1'b0;
`endif
    end else begin
`ifdef SIPO_PARITY_CHECK_EN
      par_err_q <= 1'b0;
`endif
      if (accept) begin
        if (shift_en) sreg <= shift_next;
`ifdef SIPO_PARITY_CHECK_EN
        par_acc <= restart ? sin : (par_acc ^ sin);
`endif
        if (restart) begin
          count <= CW'(1);
          state <= SHIFT;
        end else if (last_bit) begin
          count <= '0;
`ifdef SIPO_PARITY_CHECK_EN
          if (!par_ok) par_err_q <= 1'b1;
`endif
          // A bad frame is dropped outright and never parks in FULL.
          state <= (par_ok && !free) ? FULL : IDLE;
        end else begin
          count <= count + CW'(1);
        end
      end else if (state == FULL && free) begin
        state <= IDLE;
      end
    end
  end

  sipo_out_slot #(
    .WIDTH(WIDTH)
  ) u_slot (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .load_data(load_data),
    .q_data   (q_data),
    .q_valid  (q_valid),
    .q_ready  (q_ready),
    .free     (free)
  );

endmodule

// File: doc/serial_in_parallel_out.md
# serial_in_parallel_out

Serial-to-parallel deserializer that sits directly upstream of the 4-bit parallel holding register. It accumulates a serial bit stream into WIDTH-bit words and presents each word on a valid/ready output. Its parallel output drives that register's data input. A one-word output slot and an input-side ready give the serial source backpressure when the consumer stalls.

## Interface
- WIDTH, 4, data bits per word (≥2)
- MSB_FIRST, 1, 1: first received bit lands in q_data[WIDTH-1]; 0: in q_data[0]
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset; clears all state
- sin  in  1  serial data bit
- sin_valid  in  1  sin carries a bit this cycle
- sin_ready  out  1  block accepts a bit this cycle; a bit transfers when sin_valid && sin_ready
- frame_sync  in  1  qualified by sin_valid && sin_ready: this bit is bit 0 of a new frame; any partial frame is discarded
- q_data  out  WIDTH  assembled word, held stable while q_valid && !q_ready
- q_valid  out  1  q_data holds an undelivered word
- q_ready  in  1  downstream consumes q_data when q_valid && q_ready
- par_err  out  1  one-cycle pulse: parity mismatch, word dropped (tied 0 without the parity feature)

## Operation
- FRAME_LEN = WIDTH, or WIDTH+1 with parity enabled. A bit counter runs 0..FRAME_LEN-1.
- Shift register: MSB_FIRST=1 shifts left, inserting sin at bit 0. MSB_FIRST=0 shifts right, inserting at bit WIDTH-1. The parity bit is never shifted into data.
- Output slot is free when !q_valid || q_ready.
- States:
  - IDLE: count 0, sin_ready=1. An accepted bit moves to SHIFT with count 1.
  - SHIFT: sin_ready=1. Each accepted bit increments count. On the last bit of the frame: if the slot is free, load the word into q_data, set q_valid and go to IDLE. Otherwise go to FULL.
  - FULL: sin_ready=0; the complete word is held in the shift register. When the slot frees, load q_data, set q_valid and go to IDLE.
- q_valid clears on q_valid && q_ready unless a new word loads on the same edge, in which case it stays 1 with the new data.
- frame_sync on an accepted bit: count is reset to 1 and the bit is stored as the first bit, from any state that accepts input. With WIDTH=1-equivalent frames this is not applicable because WIDTH≥2.
- frame_sync with sin_valid=0, or while in FULL, is ignored.
- Reset values:
  - sin_ready=0 while rst is asserted, 1 in IDLE after reset.
  - q_data=0, q_valid=0, par_err=0, state=IDLE, count=0, shift register=0.
- Reset asserted mid-frame or in FULL discards everything immediately and asynchronously.

## Timing
- Latency: q_valid rises on the clock edge that accepts the last frame bit if the slot is free, so it is visible the next cycle.
- Throughput: one word per FRAME_LEN cycles with no bubbles under continuous sin_valid and q_ready.
- In FULL, a consume edge loads the new word on that same edge, so there is no q_valid gap.
- sin_ready depends only on registered state; there is no combinational path from q_ready to sin_ready.
- par_err is registered and asserts for exactly one cycle, following the edge that accepted the bad parity bit.

## Configuration
- Macro: SIPO_PARITY_CHECK_EN.
- Defined:
  - Frame is WIDTH data bits followed by one even-parity bit; the XOR of all WIDTH+1 bits must be 0.
  - On a match, behaviour is as above.
  - On a mismatch, the word is discarded, q_valid and q_data are unaffected, par_err pulses, and state goes to IDLE. FULL is never entered for a bad frame.
- Undefined: FRAME_LEN=WIDTH, no parity bit, and par_err is constant 0. The port exists in both builds.

## Structure
- Package sipo_pkg holds:
  - the state enum (IDLE, SHIFT, FULL)
  - the FRAME_LEN derivation
  - the counter-width function ($clog2(FRAME_LEN+1))
- Sub-module sipo_out_slot holds the one-word output register plus valid/ready logic, with ports clk, rst, load, load_data, q_data, q_valid, q_ready and free.
- The top level holds the FSM, counter, shift register and parity check.

## Test plan
All scenarios use WIDTH=4, MSB_FIRST=1 and q_ready=1 unless stated otherwise.
- Nominal: bits 1,0,1,1 on consecutive cycles -> q_data=4'b1011 and q_valid=1 one cycle after the 4th bit, for exactly one cycle.
- Backpressure: q_ready=0; send 1,0,1,1 then 0,1,1,0 -> sin_ready=0 after the 8th bit, state FULL, q_data stays 1011. Raise q_ready -> next cycle q_data=0110, q_valid stays 1 and sin_ready=1.
- frame_sync: send 1,1, then a bit 0 with frame_sync=1, then 0,1,1 -> q_data=4'b0011. The partial word 11 is never output.
- Parity (SIPO_PARITY_CHECK_EN): 1,0,1,1,parity 1 -> q_data=1011 with q_valid. Then 1,0,1,1,parity 0 -> par_err pulses for one cycle and q_valid does not assert.
- Reset mid-frame: after bits 1,0, assert rst asynchronously between edges -> all outputs 0 immediately. After release, bits 0,1,0,1 -> q_data=4'b0101.
- MSB_FIRST=0: bits 1,0,1,1 -> q_data=4'b1101.
